// File: rtl/fifo_packer_pkg.sv
// Shared defaults and state encoding for the FIFO word packer.
// Imported by the interface, the packer and its bench.
package fifo_packer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK       = 4;
  localparam int FIFO_DEPTH     = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_packer_if.sv
// FIFO read port and packed-word output handshake bundle.
// master = packer side, slave = fifo/consumer side.
interface fifo_packer_if #(
  parameter int DATA_WIDTH = fifo_packer_pkg::DEF_DATA_WIDTH,
  parameter int PACK       = fifo_packer_pkg::DEF_PACK
);

  logic                       fifo_rd_en;
  logic                       fifo_rd_val;
  logic [DATA_WIDTH-1:0]      fifo_rd_data;
  logic                       flush;
  logic                       out_val;
  logic                       out_ready;
  logic [DATA_WIDTH*PACK-1:0] out_data;
  logic [PACK-1:0]            out_mask;
  logic                       out_last;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_val,
    input  fifo_rd_data,
    input  flush,
    output out_val,
    input  out_ready,
    output out_data,
    output out_mask,
    output out_last
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_val,
    output fifo_rd_data,
    output flush,
    input  out_val,
    output out_ready,
    input  out_data,
    input  out_mask,
    input  out_last
  );

endinterface

// File: rtl/fifo_packer.sv
// Packs PACK first-word-fall-through FIFO entries into one wide word.
// Lane 0 holds the oldest entry; flush emits a partial word.
module fifo_packer
  import fifo_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK       = DEF_PACK
) (
  input  logic          clk,
  input  logic          reset,
  fifo_packer_if.master bus
);

  localparam int CW = $clog2(PACK);

  state_e                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic                               fpend_q, fpend_d;
  logic [PACK-1:0][DATA_WIDTH-1:0]    lanes_q, lanes_d;
  logic [PACK-1:0]                    mask_q, mask_d;
  logic                               last_q, last_d;

  logic            rd_en;
  logic            pop;
  logic            flush_eff;
  logic [PACK-1:0] hit;
  logic [PACK-1:0] mask_n;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fpend_d   = fpend_q;
    lanes_d   = lanes_q;
    mask_d    = mask_q;
    last_d    = last_q;
    rd_en     = 1'b0;
    pop       = 1'b0;
    flush_eff = 1'b0;
    hit       = '0;
    mask_n    = mask_q;
    unique case (state_q)
      FILL: begin
        rd_en     = bus.fifo_rd_val;
        pop       = bus.fifo_rd_val;
        flush_eff = bus.flush | fpend_q;
        fpend_d   = 1'b0;
        if (pop) begin
          hit[cnt_q]     = 1'b1;
          lanes_d[cnt_q] = bus.fifo_rd_data;
          cnt_d          = cnt_q + 1'b1;
        end
        mask_n = mask_q | hit;
        mask_d = mask_n;
        // A flush folded into the completing pop still yields one word.
        if ((pop && cnt_q == CW'(PACK - 1)) ||
            (flush_eff && (|mask_n))) begin
          state_d = HOLD;
          last_d  = flush_eff;
        end
      end
      HOLD: begin
        if (bus.flush) fpend_d = 1'b1;
        if (bus.out_ready) begin
          state_d = FILL;
          cnt_d   = '0;
          lanes_d = '0;
          mask_d  = '0;
          last_d  = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      fpend_q <= 1'b0;
      lanes_q <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fpend_q <= fpend_d;
      lanes_q <= lanes_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
    end
  end

  // Mask/last/data are only meaningful while out_val is high.
  assign bus.fifo_rd_en = rd_en;
  assign bus.out_val    = (state_q == HOLD);
  assign bus.out_data   = lanes_q;
  assign bus.out_mask   = (state_q == HOLD) ? mask_q : '0;
  assign bus.out_last   = last_q;

endmodule

// File: tb/tb_fifo_packer.sv
// Bench for fifo_packer: depth-4 FWFT fifo model, vector table,
// scoreboard of expected words and multi-cycle corner sequences.
module tb_fifo_packer;
  import fifo_packer_pkg::*;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  m;
    logic        l;
  } word_t;

  typedef struct {
    int          n;
    logic [31:0] b;
    bit          fl;
    logic [31:0] d;
    logic [3:0]  m;
    bit          l;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_packer_if #(.DATA_WIDTH(8), .PACK(4)) bus ();

  fifo_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [7:0] fmem [FIFO_DEPTH];
  logic [1:0] fwp  = '0;
  logic [1:0] frp  = '0;
  logic [2:0] fcnt = '0;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       f_push, f_pop;

  assign wr_ready         = (fcnt < 3'(FIFO_DEPTH));
  assign bus.fifo_rd_val  = (fcnt != 0);
  assign bus.fifo_rd_data = fmem[frp];
  assign f_push           = wr_en && wr_ready;
  assign f_pop            = bus.fifo_rd_en && bus.fifo_rd_val;

  always @(posedge clk) begin
    if (f_push) begin
      fmem[fwp] <= wr_data;
      fwp       <= fwp + 2'd1;
    end
    if (f_pop) frp <= frp + 2'd1;
    fcnt <= 3'(int'(fcnt) + int'(f_push) - int'(f_pop));
  end

  int    n_cmp = 0;
  int    n_bad = 0;
  word_t sb[$];
  vec_t  vt[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (reset) begin
      chk("rd_en", 32'(bus.fifo_rd_en),
          32'(bus.fifo_rd_val && !bus.out_val));
      if (bus.out_val && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", bus.out_data, 32'hxxxxxxxx);
        end else begin
          word_t w;
          w = sb.pop_front();
          chk("out_data", bus.out_data, w.d);
          chk("out_mask", 32'(bus.out_mask), 32'(w.m));
          chk("out_last", 32'(bus.out_last), 32'(w.l));
        end
      end
    end
  end

  task automatic push(input logic [7:0] d);
    int t = 0;
    while (!wr_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!wr_ready) chk("push_timeout", 32'(wr_ready), 32'd1);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] m,
                             input logic l);
    word_t w;
    w.d = d;
    w.m = m;
    w.l = l;
    sb.push_back(w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    idle(2);
  endtask

  task automatic wait_val();
    int t = 0;
    while (!bus.out_val && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("wait_val", 32'(bus.out_val), 32'd1);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    vt[0] = '{4, 32'h03020100, 1'b0, 32'h03020100, 4'b1111, 1'b0};
    vt[1] = '{4, 32'h89abcdef, 1'b1, 32'h89abcdef, 4'b1111, 1'b0};
    vt[2] = '{1, 32'h0000005a, 1'b1, 32'h0000005a, 4'b0001, 1'b1};
    vt[3] = '{3, 32'h00332211, 1'b1, 32'h00332211, 4'b0111, 1'b1};
    vt[4] = '{2, 32'h0000bbaa, 1'b1, 32'h0000bbaa, 4'b0011, 1'b1};

    idle(2);
    chk("rst_out_val", 32'(bus.out_val), 32'd0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_mask", 32'(bus.out_mask), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    reset = 1'b1;

    expect_word(32'h03020100, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) push(8'(i));
    chk("latency_pre", 32'(bus.out_val), 32'd0);
    @(negedge clk);
    chk("latency_val", 32'(bus.out_val), 32'd1);
    drain();

    for (int v = 0; v < 5; v++) begin
      expect_word(vt[v].d, vt[v].m, vt[v].l);
      for (int i = 0; i < vt[v].n; i++) push(vt[v].b[i*8 +: 8]);
      idle(3);
      if (vt[v].fl) pulse_flush();
      drain();
    end

    expect_word(32'h44434241, 4'b1111, 1'b1);
    push(8'h41);
    push(8'h42);
    push(8'h43);
    idle(3);
    push(8'h44);
    pulse_flush();
    drain();

    pulse_flush();
    for (int i = 0; i < 8; i++) begin
      chk("empty_flush", 32'(bus.out_val), 32'd0);
      @(negedge clk);
    end

    bus.out_ready = 1'b0;
    expect_word(32'h03020100, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) push(8'(i));
    wait_val();
    expect_word(32'h07060504, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push(8'(4 + i));
      chk("bp_data", bus.out_data, 32'h03020100);
      chk("bp_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    end
    chk("bp_wr_ready", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold", bus.out_data, 32'h03020100);
      chk("bp_mask", 32'(bus.out_mask), 32'hf);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    drain();

    bus.out_ready = 1'b0;
    expect_word(32'h03020100, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) push(8'(i));
    wait_val();
    expect_word(32'h00000011, 4'b0001, 1'b1);
    push(8'h11);
    pulse_flush();
    bus.out_ready = 1'b1;
    drain();

    push(8'h01);
    push(8'h02);
    idle(2);
    reset = 1'b0;
    #1;
    chk("rst_fill_data", bus.out_data, 32'd0);
    chk("rst_fill_val", 32'(bus.out_val), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    expect_word(32'h13121110, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    drain();

    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    wait_val();
    reset = 1'b0;
    #1;
    chk("rst_hold_val", 32'(bus.out_val), 32'd0);
    chk("rst_hold_mask", 32'(bus.out_mask), 32'd0);
    chk("rst_hold_last", 32'(bus.out_last), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    idle(6);
    chk("rst_hold_gone", 32'(bus.out_val), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
